mmio_console: RTL and testbench

Memory-mapped console and test-exit port on the data-memory side of the single-cycle core, downstream of its load/store path. Decodes core stores/loads in a small register window, buffers bytes in a FIFO and serializes them 8N1 on `uart_tx`. Also latches a `tohost` word that benches use as the program's pass/fail exit code instead of probing the register file.

---
 rtl/mmio_pkg.sv | 42 ++++
 rtl/mmio_console_if.sv | 31 +++
 rtl/sync_fifo.sv | 56 +++++
 rtl/mmio_console.sv | 195 +++++++++++++++++++
 tb/tb_mmio_console.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/mmio_pkg.sv
// Shared definitions for the mmio console window: register offsets, the
// STATUS bit layout and the TX serializer state encodings. The core's
// address mux and the bench import this package too.
package mmio_pkg;

    localparam logic [3:0] OFF_TXDATA = 4'h0;
    localparam logic [3:0] OFF_STATUS = 4'h4;
    localparam logic [3:0] OFF_TOHOST = 4'h8;

    localparam int ST_FULL      = 0;
    localparam int ST_EMPTY     = 1;
    localparam int ST_ACTIVE    = 2;
    localparam int ST_OVERFLOW  = 3;
    localparam int ST_COUNT_LSB = 4;
    localparam int ST_COUNT_W   = 4;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    // Assemble the STATUS register word; all bits outside the fields are zero.
    function automatic logic [31:0] status_word(
        input logic                  full,
        input logic                  empty,
        input logic                  active,
        input logic                  overflow,
        input logic [ST_COUNT_W-1:0] count
    );
        logic [31:0] w;
        w = '0;
        w[ST_FULL]                       = full;
        w[ST_EMPTY]                      = empty;
        w[ST_ACTIVE]                     = active;
        w[ST_OVERFLOW]                   = overflow;
        w[ST_COUNT_LSB +: ST_COUNT_W]    = count;
        return w;
    endfunction

endpackage

// File: rtl/mmio_console_if.sv
// Data-memory side bus between the core's load/store path and the console.
// The core is the master; mmio_console is the slave and answers with
// combinational read data plus a window-hit flag.
interface mmio_console_if;

    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        sel;

    modport master (
        output mem_we,
        output mem_re,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  sel
    );

    modport slave (
        input  mem_we,
        input  mem_re,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output sel
    );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through read data. A push into a
// full FIFO is accepted only when a pop happens in the same cycle, so the
// serializer can refill the slot it just drained.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] storage [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = storage[rd_ptr];

    // Pointer, occupancy and storage update; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                storage[wr_ptr] <= wdata;
                wr_ptr          <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mmio_console.sv
// Memory-mapped console and test-exit port. Decodes a three-register window
// (TXDATA, STATUS, TOHOST), queues console bytes in a small FIFO and sends
// them 8N1 on uart_tx, and latches the program's exit code in tohost.
module mmio_console
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic                clk,
    input  logic                reset,
    mmio_console_if.slave       bus,
    output logic                uart_tx,
    output logic                tohost_valid,
    output logic [31:0]         tohost_value
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    logic             hit;
    logic [3:0]       offset;
    logic             wr_txdata;
    logic             wr_status;
    logic             wr_tohost;
    logic             unused_load_strobe;

    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_rdata;
    logic [CNT_W-1:0] fifo_count;
    logic             push_dropped;
    logic             overflow;
    logic [31:0]      status;

    tx_state_t        state;
    tx_state_t        state_n;
    logic [BAUD_W-1:0] baud_cnt;
    logic [BAUD_W-1:0] baud_n;
    logic [2:0]       bit_idx;
    logic [2:0]       bit_n;
    logic [7:0]       shreg;
    logic [7:0]       shreg_n;
    logic             tx_n;
    logic             baud_done;

    assign offset = bus.mem_addr[3:0];
    assign hit    = (bus.mem_addr[31:4] == BASE_ADDR[31:4])
                 && (bus.mem_addr[3:2] != 2'b11)
                 && (bus.mem_addr[1:0] == 2'b00);
    assign bus.sel = hit;

    // Reads have no side effects here, so the load strobe is not needed for decode.
    assign unused_load_strobe = bus.mem_re;

    assign wr_txdata = hit && bus.mem_we && (offset == OFF_TXDATA);
    assign wr_status = hit && bus.mem_we && (offset == OFF_STATUS);
    assign wr_tohost = hit && bus.mem_we && (offset == OFF_TOHOST);

    assign push_dropped = wr_txdata && fifo_full && !fifo_pop;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_txdata),
        .pop   (fifo_pop),
        .wdata (bus.mem_wdata[7:0]),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign status = status_word(fifo_full, fifo_empty, (state != TX_IDLE),
                                overflow, ST_COUNT_W'(fifo_count));

    // Read mux shows pre-edge register state, so a same-cycle store is not visible yet.
    always_comb begin
        bus.mem_rdata = '0;
        if (hit) begin
            case (offset)
                OFF_STATUS: bus.mem_rdata = status;
                OFF_TOHOST: bus.mem_rdata = tohost_value;
                default:    bus.mem_rdata = '0;
            endcase
        end
    end

    // Exit-code latch and sticky overflow flag; a dropped byte wins over a clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            tohost_valid <= 1'b0;
            tohost_value <= '0;
            overflow     <= 1'b0;
        end else begin
            if (wr_tohost) begin
                tohost_valid <= 1'b1;
                tohost_value <= bus.mem_wdata;
            end
            if (push_dropped) begin
                overflow <= 1'b1;
            end else if (wr_status && bus.mem_wdata[ST_OVERFLOW]) begin
                overflow <= 1'b0;
            end
        end
    end

    assign baud_done = (baud_cnt == BAUD_LAST);

    // Serializer next-state: uart_tx is registered, so tx_n is the level for the coming state/bit.
    always_comb begin
        state_n  = state;
        baud_n   = baud_cnt + BAUD_W'(1);
        bit_n    = bit_idx;
        shreg_n  = shreg;
        tx_n     = uart_tx;
        fifo_pop = 1'b0;
        case (state)
            TX_IDLE: begin
                baud_n = '0;
                tx_n   = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shreg_n  = fifo_rdata;
                    state_n  = TX_START;
                    tx_n     = 1'b0;
                end
            end
            TX_START: begin
                if (baud_done) begin
                    baud_n  = '0;
                    bit_n   = '0;
                    state_n = TX_DATA;
                    tx_n    = shreg[0];
                end
            end
            TX_DATA: begin
                if (baud_done) begin
                    baud_n = '0;
                    if (bit_idx == 3'd7) begin
                        state_n = TX_STOP;
                        tx_n    = 1'b1;
                    end else begin
                        bit_n   = bit_idx + 3'd1;
                        shreg_n = {1'b0, shreg[7:1]};
                        tx_n    = shreg[1];
                    end
                end
            end
            TX_STOP: begin
                if (baud_done) begin
                    baud_n = '0;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shreg_n  = fifo_rdata;
                        state_n  = TX_START;
                        tx_n     = 1'b0;
                    end else begin
                        state_n = TX_IDLE;
                        tx_n    = 1'b1;
                    end
                end
            end
            default: begin
                state_n = TX_IDLE;
                baud_n  = '0;
                tx_n    = 1'b1;
            end
        endcase
    end

    // Serializer registers; reset drops any partial frame and forces the line idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= TX_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            uart_tx  <= 1'b1;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_n;
            bit_idx  <= bit_n;
            shreg    <= shreg_n;
            uart_tx  <= tx_n;
        end
    end

endmodule

// File: tb/tb_mmio_console.sv
// Directed bench for mmio_console with CLKS_PER_BIT=4 and FIFO_DEPTH=4.
// Expected UART line levels and register values are written out by hand.
module tb_mmio_console;
    import mmio_pkg::*;

    localparam int CPB = 4;

    logic        clk;
    logic        reset;
    logic        uart_tx;
    logic        tohost_valid;
    logic [31:0] tohost_value;
    int          errors;
    int          checks;

    mmio_console_if bus();

    mmio_console #(
        .BASE_ADDR    (32'h0000_1000),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .uart_tx      (uart_tx),
        .tohost_valid (tohost_valid),
        .tohost_value (tohost_value)
    );

    // Free-running clock, 10 time units per cycle.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case something runs away.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic we, input logic re,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        bus.mem_we    = we;
        bus.mem_re    = re;
        bus.mem_addr  = addr;
        bus.mem_wdata = wdata;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic busWrite(input logic [31:0] addr, input logic [31:0] wdata);
        applyStimulus(1'b1, 1'b0, addr, wdata);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic busRead(input string tag, input logic [31:0] addr,
                           input logic [31:0] expected);
        applyStimulus(1'b0, 1'b1, addr, 32'h0);
        #1;
        checkOutput(tag, bus.mem_rdata, expected);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    // Walks one 10-slot frame, one tick per cycle; skip = cycles of it already elapsed.
    task automatic checkFrame(input logic [7:0] b, input int skip);
        logic exp_bit;
        int   slot;
        for (int k = skip; k < 10 * CPB; k++) begin
            tick();
            slot = k / CPB;
            if (slot == 0)      exp_bit = 1'b0;
            else if (slot == 9) exp_bit = 1'b1;
            else                exp_bit = b[slot-1];
            checkOutput($sformatf("frame_%h_cyc%0d", b, k), {31'b0, uart_tx}, {31'b0, exp_bit});
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        tick();
        reset = 1'b0;

        $display("[TB] reset and idle");
        for (int i = 0; i < 50; i++) tick();
        checkOutput("idle_tx", {31'b0, uart_tx}, 32'h1);
        checkOutput("idle_valid", {31'b0, tohost_valid}, 32'h0);
        checkOutput("idle_value", tohost_value, 32'h0);
        busRead("idle_status", 32'h0000_1004, 32'h0000_0002);
        busRead("idle_txdata_read", 32'h0000_1000, 32'h0000_0000);

        $display("[TB] single byte 0x41");
        busWrite(32'h0000_1000, 32'h0000_0041);
        checkOutput("pop_latency_tx", {31'b0, uart_tx}, 32'h1);
        busRead("status_after_push", 32'h0000_1004, 32'h0000_0010);
        checkFrame(8'h41, 0);
        tick();
        checkOutput("post_frame_tx", {31'b0, uart_tx}, 32'h1);
        busRead("post_frame_status", 32'h0000_1004, 32'h0000_0002);

        $display("[TB] burst with overflow");
        for (int i = 0; i < 6; i++) begin
            busWrite(32'h0000_1000, 32'h0000_0030 + 32'(i));
        end
        busRead("burst_status", 32'h0000_1004, 32'h0000_004D);
        checkFrame(8'h30, 5);
        checkFrame(8'h31, 0);
        checkFrame(8'h32, 0);
        checkFrame(8'h33, 0);
        checkFrame(8'h34, 0);
        for (int i = 0; i < 8; i++) tick();
        checkOutput("burst_idle_tx", {31'b0, uart_tx}, 32'h1);
        busRead("burst_done_status", 32'h0000_1004, 32'h0000_000A);
        busWrite(32'h0000_1004, 32'h0000_0008);
        busRead("ovf_cleared_status", 32'h0000_1004, 32'h0000_0002);

        $display("[TB] tohost");
        busWrite(32'h0000_1008, 32'd15);
        checkOutput("tohost_valid_1", {31'b0, tohost_valid}, 32'h1);
        checkOutput("tohost_value_15", tohost_value, 32'd15);
        busRead("tohost_read_15", 32'h0000_1008, 32'd15);
        busWrite(32'h0000_1008, 32'd7);
        checkOutput("tohost_value_7", tohost_value, 32'd7);
        checkOutput("tohost_valid_sticky", {31'b0, tohost_valid}, 32'h1);

        $display("[TB] decode boundaries");
        applyStimulus(1'b1, 1'b0, 32'h0000_1001, 32'h0000_0099);
        #1;
        checkOutput("sel_misaligned", {31'b0, bus.sel}, 32'h0);
        tick();
        applyStimulus(1'b1, 1'b0, 32'h0000_100C, 32'h0000_0099);
        #1;
        checkOutput("sel_off_c", {31'b0, bus.sel}, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b1, 32'h0000_2004, 32'h0);
        #1;
        checkOutput("sel_other_base", {31'b0, bus.sel}, 32'h0);
        checkOutput("rdata_unselected", bus.mem_rdata, 32'h0);
        applyStimulus(1'b0, 1'b1, 32'h0000_1004, 32'h0);
        #1;
        checkOutput("sel_status", {31'b0, bus.sel}, 32'h1);
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        busRead("decode_status", 32'h0000_1004, 32'h0000_0002);
        checkOutput("decode_tx_idle", {31'b0, uart_tx}, 32'h1);
        checkOutput("decode_valid", {31'b0, tohost_valid}, 32'h1);
        checkOutput("decode_value", tohost_value, 32'd7);

        $display("[TB] reset mid-frame");
        busWrite(32'h0000_1000, 32'h0000_0055);
        busWrite(32'h0000_1000, 32'h0000_00AA);
        busWrite(32'h0000_1000, 32'h0000_00BB);
        busRead("queued_status", 32'h0000_1004, 32'h0000_0024);
        for (int i = 0; i < 7; i++) tick();
        checkOutput("mid_data_bit1", {31'b0, uart_tx}, 32'h0);
        reset = 1'b1;
        applyStimulus(1'b1, 1'b0, 32'h0000_1000, 32'h0000_0077);
        tick();
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 32'h0);
        checkOutput("reset_tx_high", {31'b0, uart_tx}, 32'h1);
        checkOutput("reset_valid", {31'b0, tohost_valid}, 32'h0);
        checkOutput("reset_value", tohost_value, 32'h0);
        busRead("reset_status", 32'h0000_1004, 32'h0000_0002);
        for (int i = 0; i < 60; i++) begin
            tick();
            checkOutput($sformatf("post_reset_line_cyc%0d", i), {31'b0, uart_tx}, 32'h1);
        end
        busRead("post_reset_status", 32'h0000_1004, 32'h0000_0002);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
